// File: rtl/mvprod_chunk_sequencer.sv
// Chunk buffer and result collector for one MVProd layer: loads an input vector as
// WORKING_REGS-wide chunks, serves MVProd chunk requests, then streams the results out.
module mvprod_chunk_sequencer #(
    parameter int IN_VEC_LEN   = 12,
    parameter int OUT_VEC_LEN  = 8,
    parameter int WORKING_REGS = 3
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         s_chunk_valid,
    output logic                         s_chunk_ready,
    input  logic [WORKING_REGS-1:0][7:0] s_chunk_data,
    output logic [WORKING_REGS-1:0][7:0] mv_in_data,
    output logic                         mv_in_data_ready,
    input  logic                         mv_req_chunk_in,
    input  logic                         mv_req_chunk_ptr_rst,
    input  logic                         mv_req_chunk_out,
    input  logic [7:0]                   mv_write_out_data,
    output logic                         m_out_valid,
    input  logic                         m_out_ready,
    output logic [7:0]                   m_out_data,
    output logic                         m_out_last,
    output logic                         busy,
    output logic                         err_overflow,
    output logic [1:0]                   dbg_state
);

    localparam int CHUNKS = IN_VEC_LEN / WORKING_REGS;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int OW     = (OUT_VEC_LEN > 1) ? $clog2(OUT_VEC_LEN) : 1;

    // Handshakes: a transfer happens on a rising clk_in edge where valid and ready are both 1;
    // data and last are held stable while valid=1 and ready=0.
    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] out_wr_ptr, out_rd_ptr;
    logic [WORKING_REGS-1:0][7:0] chunk_buf [CHUNKS];
    logic [7:0] out_buf [OUT_VEC_LEN];

    logic load_hs, last_chunk, cap, last_cap, drain_hs, last_out;

    assign load_hs    = (state == ST_LOAD) && s_chunk_valid;
    assign last_chunk = (wr_ptr == CW'(CHUNKS - 1));
    assign cap        = (state == ST_COMPUTE) && mv_req_chunk_out;
    assign last_cap   = cap && (out_wr_ptr == OW'(OUT_VEC_LEN - 1));
    assign last_out   = (out_rd_ptr == OW'(OUT_VEC_LEN - 1));
    assign drain_hs   = (state == ST_DRAIN) && m_out_ready;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ST_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:    if (load_hs && last_chunk) state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (last_cap)              state_nxt = ST_DRAIN;
            ST_DRAIN:   if (drain_hs && last_out)  state_nxt = ST_LOAD;
            default:                               state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        s_chunk_ready = (state == ST_LOAD) && !rst_in;
        m_out_valid   = (state == ST_DRAIN);
        m_out_data    = (state == ST_DRAIN) ? out_buf[out_rd_ptr] : 8'd0;
        m_out_last    = (state == ST_DRAIN) && last_out;
        busy          = (state == ST_COMPUTE) || (state == ST_DRAIN);
        mv_in_data    = rst_in ? '0 : chunk_buf[rd_ptr];
        dbg_state     = state;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            out_wr_ptr       <= '0;
            out_rd_ptr       <= '0;
            mv_in_data_ready <= 1'b0;
            err_overflow     <= 1'b0;
        end else begin
            mv_in_data_ready <= load_hs && last_chunk;
            if (load_hs)
                wr_ptr <= last_chunk ? '0 : wr_ptr + 1'b1;
            // Pointer rewind wins over advance; a final capture also rewinds for the next vector.
            if (state == ST_COMPUTE) begin
                if (last_cap || mv_req_chunk_ptr_rst)
                    rd_ptr <= '0;
                else if (mv_req_chunk_in)
                    rd_ptr <= (rd_ptr == CW'(CHUNKS - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (cap)
                out_wr_ptr <= last_cap ? '0 : out_wr_ptr + 1'b1;
            if (drain_hs)
                out_rd_ptr <= last_out ? '0 : out_rd_ptr + 1'b1;
            if (mv_req_chunk_out && (state != ST_COMPUTE))
                err_overflow <= 1'b1;
        end
    end

    // Storage carries no reset; contents are only read after being written.
    always_ff @(posedge clk_in) begin
        if (load_hs) chunk_buf[wr_ptr] <= s_chunk_data;
        if (cap)     out_buf[out_wr_ptr] <= mv_write_out_data;
    end

endmodule

// File: tb/tb_mvprod_chunk_sequencer.sv
// Directed bench for mvprod_chunk_sequencer (WR=3, 6-element input, 4 results) with a
// result scoreboard and a small all-ones-weight MVProd model for back-to-back vectors.
module tb_mvprod_chunk_sequencer;

    localparam int WR     = 3;
    localparam int IN_LEN = 6;
    localparam int OUT_LEN = 4;
    localparam int CHUNKS = IN_LEN / WR;

    typedef logic [WR-1:0][7:0] chunk_t;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       s_chunk_valid = 1'b0;
    logic       s_chunk_ready;
    chunk_t     s_chunk_data = '0;
    chunk_t     mv_in_data;
    logic       mv_in_data_ready;
    logic       mv_req_chunk_in = 1'b0;
    logic       mv_req_chunk_ptr_rst = 1'b0;
    logic       mv_req_chunk_out = 1'b0;
    logic [7:0] mv_write_out_data = '0;
    logic       m_out_valid;
    logic       m_out_ready = 1'b0;
    logic [7:0] m_out_data;
    logic       m_out_last;
    logic       busy;
    logic       err_overflow;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    mvprod_chunk_sequencer #(
        .IN_VEC_LEN(IN_LEN), .OUT_VEC_LEN(OUT_LEN), .WORKING_REGS(WR)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .s_chunk_valid(s_chunk_valid), .s_chunk_ready(s_chunk_ready), .s_chunk_data(s_chunk_data),
        .mv_in_data(mv_in_data), .mv_in_data_ready(mv_in_data_ready),
        .mv_req_chunk_in(mv_req_chunk_in), .mv_req_chunk_ptr_rst(mv_req_chunk_ptr_rst),
        .mv_req_chunk_out(mv_req_chunk_out), .mv_write_out_data(mv_write_out_data),
        .m_out_valid(m_out_valid), .m_out_ready(m_out_ready), .m_out_data(m_out_data),
        .m_out_last(m_out_last), .busy(busy), .err_overflow(err_overflow), .dbg_state(dbg_state)
    );

    // Clock / watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Checking and driver tasks
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_chunk(input chunk_t d);
        s_chunk_valid = 1'b1;
        s_chunk_data  = d;
        check("chunk_ready", s_chunk_ready, 1);
        step();
        s_chunk_valid = 1'b0;
    endtask

    task automatic load_vector(input chunk_t c0, input chunk_t c1, output logic [7:0] sum);
        sum = 8'd0;
        for (int e = 0; e < WR; e++) sum = sum + c0[e] + c1[e];
        send_chunk(c0);
        send_chunk(c1);
    endtask

    task automatic capture(input logic [7:0] d, input bit expect_it);
        mv_req_chunk_out  = 1'b1;
        mv_write_out_data = d;
        if (expect_it) exp_q.push_back(d);
        step();
        mv_req_chunk_out  = 1'b0;
    endtask

    task automatic pulse_req(input bit adv, input bit rew);
        mv_req_chunk_in      = adv;
        mv_req_chunk_ptr_rst = rew;
        step();
        mv_req_chunk_in      = 1'b0;
        mv_req_chunk_ptr_rst = 1'b0;
    endtask

    task automatic drain_cycle(input bit r, inout int got);
        m_out_ready = r;
        check("drain_valid", m_out_valid, 1);
        if (exp_q.size() == 0) begin
            check("drain_underflow", 0, 1);
        end else begin
            check("drain_data", m_out_data, exp_q[0]);
            check("drain_last", m_out_last, exp_q.size() == 1);
            if (r) begin
                void'(exp_q.pop_front());
                got++;
            end
        end
        step();
        m_out_ready = 1'b0;
    endtask

    task automatic drain(input int n, input bit rnd);
        int got = 0;
        int cyc = 0;
        bit r;
        while (got < n && cyc < 200) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            drain_cycle(r, got);
            cyc++;
        end
        check("drain_count", got, n);
    endtask

    // All-ones-weight MVProd: each result is the int8 sum of every input element.
    task automatic run_mvprod();
        int n = 0;
        logic [7:0] acc;
        while (!mv_in_data_ready && n < 50) begin step(); n++; end
        check("mv_start", mv_in_data_ready, 1);
        for (int j = 0; j < OUT_LEN; j++) begin
            acc = 8'd0;
            for (int k = 0; k < CHUNKS; k++) begin
                for (int e = 0; e < WR; e++) acc = acc + mv_in_data[e];
                if (k == CHUNKS - 1) begin
                    mv_req_chunk_ptr_rst = 1'b1;
                    mv_req_chunk_out     = 1'b1;
                    mv_write_out_data    = acc;
                end else begin
                    mv_req_chunk_in = 1'b1;
                end
                step();
                mv_req_chunk_in      = 1'b0;
                mv_req_chunk_ptr_rst = 1'b0;
                mv_req_chunk_out     = 1'b0;
            end
        end
    endtask

    // Directed sequence
    initial begin
        logic [7:0] sum;
        logic [7:0] vals [4];
        chunk_t c0, c1;
        int got;

        repeat (2) @(posedge clk_in);
        #1;
        check("rst_s_ready", s_chunk_ready, 0);
        check("rst_pulse", mv_in_data_ready, 0);
        check("rst_valid", m_out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_overflow, 0);
        check("rst_mv_data", mv_in_data, 0);
        check("rst_state", dbg_state, 0);
        rst_in = 1'b0;
        #1;
        check("load_ready", s_chunk_ready, 1);

        // Vector 1: pointer walk, captures, overflow while draining
        load_vector(24'h010203, 24'h040506, sum);
        check("compute_s_ready", s_chunk_ready, 0);
        check("start_pulse", mv_in_data_ready, 1);
        check("busy_compute", busy, 1);
        check("mv_data_c0", mv_in_data, 24'h010203);
        step();
        check("start_pulse_end", mv_in_data_ready, 0);
        pulse_req(1, 0);
        check("mv_data_adv1", mv_in_data, 24'h040506);
        pulse_req(1, 0);
        check("mv_data_wrap", mv_in_data, 24'h010203);
        pulse_req(1, 0);
        check("mv_data_adv2", mv_in_data, 24'h040506);
        pulse_req(1, 1);
        check("mv_data_rew_prio", mv_in_data, 24'h010203);
        pulse_req(1, 0);
        check("mv_data_pre_cap", mv_in_data, 24'h040506);
        capture(8'd5, 1);
        capture(8'hFD, 1);
        capture(8'h7F, 1);
        check("valid_before_last_cap", m_out_valid, 0);
        capture(8'h80, 1);
        check("drain_entered", m_out_valid, 1);
        check("rd_ptr_rewound", mv_in_data, 24'h010203);
        check("err_clean", err_overflow, 0);

        mv_req_chunk_out  = 1'b1;
        mv_write_out_data = 8'h55;
        step();
        mv_req_chunk_out  = 1'b0;
        check("err_set", err_overflow, 1);

        got = 0;
        drain_cycle(1, got);
        drain_cycle(0, got);
        drain_cycle(1, got);
        drain_cycle(0, got);
        drain_cycle(1, got);
        drain_cycle(1, got);
        check("pattern_count", got, 4);
        check("back_to_load", s_chunk_ready, 1);
        check("load_valid_low", m_out_valid, 0);
        check("load_busy_low", busy, 0);

        // Vector 2: abandoned by reset after one capture
        load_vector(24'h0A0B0C, 24'h0D0E0F, sum);
        check("err_sticky", err_overflow, 1);
        capture(8'h33, 0);
        rst_in = 1'b1;
        #1;
        check("midrst_s_ready", s_chunk_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", err_overflow, 0);
        check("midrst_mv_data", mv_in_data, 0);
        check("midrst_valid", m_out_valid, 0);
        step();
        rst_in = 1'b0;
        #1;
        check("postrst_ready", s_chunk_ready, 1);

        // Vector 3: full vector after reset
        load_vector(24'hA1B2C3, 24'h00FF80, sum);
        for (int i = 0; i < OUT_LEN; i++) vals[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < OUT_LEN; i++) capture(vals[i], 1);
        drain(OUT_LEN, 0);

        // Back-to-back vectors through the MVProd model
        for (int v = 0; v < 3; v++) begin
            c0 = chunk_t'($urandom);
            c1 = chunk_t'($urandom);
            load_vector(c0, c1, sum);
            for (int i = 0; i < OUT_LEN; i++) exp_q.push_back(sum);
            run_mvprod();
            drain(OUT_LEN, 1);
        end
        check("err_stays_clear", err_overflow, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
